mul_seq_controller: RTL

//  Sequencer for the shift-add multiplier datapath (Product register + 32-bit ALU).

---
 rtl/mul_seq_controller_if.sv | 28 ++
 rtl/mul_seq_controller.sv | 72 +++++++
 2 files changed

// File: rtl/mul_seq_controller_if.sv
// Control/status bundle between the shift-add multiplier sequencer and its requester/datapath.
// The master side issues requests and reflects datapath state; the slave side is the sequencer.
interface mul_seq_controller_if #(
    parameter int CNT_W = 6
);
    logic             start;
    logic             abort;
    logic             product_lsb;
    logic             ALU_carry;
    logic             W_ctrl;
    logic             SRL_ctrl;
    logic             alu_add;
    logic             Ready;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] iter_cnt;

    modport master (
        output start, abort, product_lsb, ALU_carry,
        input  W_ctrl, SRL_ctrl, alu_add, Ready, busy, done, err, iter_cnt
    );

    modport slave (
        input  start, abort, product_lsb, ALU_carry,
        output W_ctrl, SRL_ctrl, alu_add, Ready, busy, done, err, iter_cnt
    );
endinterface

// File: rtl/mul_seq_controller.sv
// Sequencer for a shift-add multiplier: one Product load cycle, WIDTH add/shift steps,
// then Ready holds the result. Carry-out is an overflow error; abort cancels a running op.
module mul_seq_controller #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 Reset,
    mul_seq_controller_if.slave  bus,
    output logic [2:0]           state_dbg
);
    // Handshake: start is a level request accepted only in IDLE, DONE or ERR; the op it
    // launches ends with a one-cycle done pulse, and Ready stays high until the next start.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last_step;

    assign last_step = (bus.iter_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (bus.start) state_nxt = S_LOAD;
            S_LOAD: state_nxt = bus.abort ? S_IDLE : S_RUN;
            S_RUN: begin
                if (bus.abort)          state_nxt = S_IDLE;
                else if (bus.ALU_carry) state_nxt = S_ERR;
                else if (last_step)     state_nxt = S_DONE;
            end
            S_DONE, S_ERR: if (bus.start) state_nxt = S_LOAD;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet aligned with it.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state        <= S_IDLE;
            bus.iter_cnt <= '0;
            bus.W_ctrl   <= 1'b0;
            bus.SRL_ctrl <= 1'b0;
            bus.Ready    <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            state        <= state_nxt;
            bus.W_ctrl   <= (state_nxt == S_LOAD);
            bus.SRL_ctrl <= (state_nxt == S_RUN);
            bus.busy     <= (state_nxt == S_LOAD) || (state_nxt == S_RUN);
            bus.Ready    <= (state_nxt == S_DONE);
            bus.done     <= (state == S_RUN) && (state_nxt == S_DONE);
            bus.err      <= (state_nxt == S_ERR);
            // Every RUN cycle is a step, including one that ends in abort or carry.
            if (state_nxt == S_LOAD)
                bus.iter_cnt <= '0;
            else if (state == S_RUN)
                bus.iter_cnt <= bus.iter_cnt + 1'b1;
        end
    end

    assign bus.alu_add = bus.SRL_ctrl & bus.product_lsb;
    assign state_dbg   = state;
endmodule
